// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by
// the word-aligned PC, with a one-stage pending-update register that is
// bypassed to lookups and to back-to-back feedback on the same index.
// Optional statistics counters are built when BRANCH_PREDICTOR_STATS_EN
// is defined.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;
    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;
endpackage

module branch_predictor #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_req_valid,
    input  logic [ADDR_WIDTH-1:0]       i_req_pc,
    output mips_core_pkg::BranchOutcome o_prediction,
    input  logic                        i_fb_valid,
    input  logic [ADDR_WIDTH-1:0]       i_fb_pc,
    input  mips_core_pkg::BranchOutcome i_fb_outcome,
    input  mips_core_pkg::BranchOutcome i_fb_prediction
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0]                 o_stat_branches,
    output logic [31:0]                 o_stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            table_q [ENTRIES];
    logic [1:0]            table_d [ENTRIES];
    logic                  pend_vld_q, pend_vld_d;
    logic [INDEX_BITS-1:0] pend_idx_q, pend_idx_d;
    logic [1:0]            pend_val_q, pend_val_d;

    logic [INDEX_BITS-1:0] req_idx;
    logic [INDEX_BITS-1:0] fb_idx;
    logic [1:0]            req_ctr;
    logic [1:0]            fb_ctr;

    // Byte-offset bits and bits above the index never affect the table.
    logic unused_inputs;
    assign unused_inputs = ^{i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_req_pc[1:0],
                             i_fb_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_fb_pc[1:0],
                             i_fb_prediction};

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'b01;
        end
        return res;
    endfunction

    assign req_idx = i_req_pc[INDEX_BITS+1:2];
    assign fb_idx  = i_fb_pc[INDEX_BITS+1:2];

    // Effective counters: the pending update overrides the (not yet written) table entry.
    always_comb begin
        req_ctr = table_q[req_idx];
        if (pend_vld_q && (pend_idx_q == req_idx)) req_ctr = pend_val_q;
        fb_ctr = table_q[fb_idx];
        if (pend_vld_q && (pend_idx_q == fb_idx)) fb_ctr = pend_val_q;
        o_prediction = mips_core_pkg::NOT_TAKEN;
        if (!rst && i_req_valid && req_ctr[1]) o_prediction = mips_core_pkg::TAKEN;
    end

    // Feedback is captured into the pending stage, built on the effective counter.
    always_comb begin
        pend_vld_d = i_fb_valid;
        pend_idx_d = fb_idx;
        pend_val_d = sat_update(fb_ctr, i_fb_outcome == mips_core_pkg::TAKEN);
    end

    // Last cycle's pending update retires into the table.
    always_comb begin
        table_d = table_q;
        if (pend_vld_q) table_d[pend_idx_q] = pend_val_q;
    end

    // Table and pending-stage registers; reset drops any in-flight update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
            pend_val_q <= 2'b01;
        end else begin
            table_q    <= table_d;
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            pend_val_q <= pend_val_d;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mis_q, stat_mis_d;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Count resolved branches and those whose carried prediction was wrong.
    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (i_fb_valid) begin
            stat_br_d = sat_inc32(stat_br_q);
            if (i_fb_prediction != i_fb_outcome) stat_mis_d = sat_inc32(stat_mis_q);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign o_stat_branches    = stat_br_q;
    assign o_stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, training, bypass, saturation,
// aliasing, reset during a pending update and (with the stats macro) counters.

module tb_branch_predictor;
    import mips_core_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [31:0]  req_pc = '0;
    BranchOutcome prediction;
    logic         fb_valid = 1'b0;
    logic [31:0]  fb_pc = '0;
    BranchOutcome fb_outcome = NOT_TAKEN;
    BranchOutcome fb_prediction = NOT_TAKEN;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0]  stat_branches;
    logic [31:0]  stat_mispredicts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    branch_predictor #(.INDEX_BITS(7), .ADDR_WIDTH(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_req_valid        (req_valid),
        .i_req_pc           (req_pc),
        .o_prediction       (prediction),
        .i_fb_valid         (fb_valid),
        .i_fb_pc            (fb_pc),
        .i_fb_outcome       (fb_outcome),
        .i_fb_prediction    (fb_prediction)
`ifdef BRANCH_PREDICTOR_STATS_EN
        ,
        .o_stat_branches    (stat_branches),
        .o_stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fb(input logic [31:0] pc, input BranchOutcome outc, input BranchOutcome pred);
        step();
        fb_valid      = 1'b1;
        fb_pc         = pc;
        fb_outcome    = outc;
        fb_prediction = pred;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            fb_valid = 1'b0;
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input BranchOutcome exp);
        req_pc = pc;
        #2;
        check(tag, {31'b0, prediction}, {31'b0, exp});
    endtask

    initial begin
        logic [31:0] pcs [4];
        pcs[0] = 32'h0000_0000; pcs[1] = 32'h0040_0020;
        pcs[2] = 32'h0000_01FC; pcs[3] = 32'h0040_0010;

        // Reset window
        req_valid = 1'b1;
        req_pc    = 32'h0040_0010;
        #2;
        check("pred_in_reset", {31'b0, prediction}, {31'b0, NOT_TAKEN});
`ifdef BRANCH_PREDICTOR_STATS_EN
        check("stat_br_reset", stat_branches, 32'd0);
        check("stat_mis_reset", stat_mispredicts, 32'd0);
`endif
        step();
        step();
        rst = 1'b0;
        lookup("first_lookup", 32'h0040_0010, NOT_TAKEN);
        for (int i = 0; i < 4; i++) lookup($sformatf("init_nt_%0d", i), pcs[i], NOT_TAKEN);
        req_valid = 1'b0;
        #1;
        check("req_invalid", {31'b0, prediction}, {31'b0, NOT_TAKEN});
        req_valid = 1'b1;

        // Two back-to-back TAKEN on the same index -> 11
        drive_fb(32'h0040_0010, TAKEN, NOT_TAKEN);
        lookup("same_cycle_pre", 32'h0040_0010, NOT_TAKEN);
        drive_fb(32'h0040_0010, TAKEN, NOT_TAKEN);
        lookup("b2b_pending_10", 32'h0040_0010, TAKEN);
        idle(2);
        lookup("b2b_taken", 32'h0040_0010, TAKEN);
        drive_fb(32'h0040_0010, NOT_TAKEN, TAKEN);
        idle(2);
        lookup("ctr_was_11", 32'h0040_0010, TAKEN);
        drive_fb(32'h0040_0010, NOT_TAKEN, TAKEN);
        idle(2);
        lookup("dec_to_01", 32'h0040_0010, NOT_TAKEN);

        // Bypass of a single pending update
        drive_fb(32'h0040_0020, TAKEN, NOT_TAKEN);
        lookup("bypass_pre", 32'h0040_0020, NOT_TAKEN);
        idle(1);
        lookup("bypass_pending", 32'h0040_0020, TAKEN);
        idle(2);
        lookup("bypass_written", 32'h0040_0020, TAKEN);

        // Saturation at 00 over five consecutive NOT_TAKEN
        for (int k = 0; k < 5; k++) begin
            drive_fb(32'h0040_0030, NOT_TAKEN, NOT_TAKEN);
            lookup($sformatf("sat_step_%0d", k), 32'h0040_0030, NOT_TAKEN);
        end
        idle(2);
        lookup("sat_final", 32'h0040_0030, NOT_TAKEN);
        drive_fb(32'h0040_0030, TAKEN, NOT_TAKEN);
        idle(2);
        lookup("sat_inc_to_01", 32'h0040_0030, NOT_TAKEN);

        // Aliasing across PCs sharing an index
        drive_fb(32'h0000_0004, TAKEN, NOT_TAKEN);
        drive_fb(32'h0000_0004, TAKEN, NOT_TAKEN);
        idle(2);
        lookup("alias_0x204", 32'h0000_0204, TAKEN);
        lookup("neighbor_0x8", 32'h0000_0008, NOT_TAKEN);

        // Back-to-back feedback to different indices
        drive_fb(32'h0000_0050, TAKEN, NOT_TAKEN);
        drive_fb(32'h0000_0054, TAKEN, NOT_TAKEN);
        idle(2);
        lookup("b2b_diff_a", 32'h0000_0050, TAKEN);
        lookup("b2b_diff_b", 32'h0000_0054, TAKEN);

        // Clean reset so the statistics start from zero
        rst = 1'b1;
        #2;
        rst = 1'b0;
        lookup("reset_clears_alias", 32'h0000_0004, NOT_TAKEN);

        // Ten feedbacks, three mispredicted; the last one trains 0x100
        for (int i = 0; i < 10; i++) begin
            drive_fb((i == 9) ? 32'h0000_0100 : (32'h0000_0180 + 32'(4 * i)), TAKEN,
                     (i == 1 || i == 4 || i == 7) ? NOT_TAKEN : TAKEN);
        end
        step();
        fb_valid = 1'b0;
        lookup("pending_visible", 32'h0000_0100, TAKEN);
`ifdef BRANCH_PREDICTOR_STATS_EN
        check("stat_branches_10", stat_branches, 32'd10);
        check("stat_mispredicts_3", stat_mispredicts, 32'd3);
`endif
        // Asynchronous reset while the update to 0x100 is pending
        rst = 1'b1;
        #1;
        check("pred_async_rst", {31'b0, prediction}, {31'b0, NOT_TAKEN});
`ifdef BRANCH_PREDICTOR_STATS_EN
        check("stat_br_cleared", stat_branches, 32'd0);
        check("stat_mis_cleared", stat_mispredicts, 32'd0);
`endif
        step();
        rst = 1'b0;
        lookup("pending_dropped", 32'h0000_0100, NOT_TAKEN);
        idle(2);
        lookup("pending_dropped_late", 32'h0000_0100, NOT_TAKEN);
        lookup("post_rst_other", 32'h0000_0050, NOT_TAKEN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL use parameter INDEX_BITS, default 7: log2 of pattern-table entries (128).
REQ-002 SHALL use parameter ADDR_WIDTH, default `ADDR_WIDTH (32): PC width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL provide port clk, input, 1 bit: single clock; all state on rising edge.
REQ-005 SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL provide port i_req_valid, input, 1 bit: decode stage holds a branch/jump needing a prediction.
REQ-007 SHALL provide port i_req_pc, input, ADDR_WIDTH bits: PC of the decoding branch.
REQ-008 SHALL provide port o_prediction, output, mips_core_pkg::BranchOutcome: predicted outcome for i_req_pc.
REQ-009 SHALL provide port i_fb_valid, input, 1 bit: ALU-stage branch result valid this cycle.
REQ-010 SHALL provide port i_fb_pc, input, ADDR_WIDTH bits: PC of the resolved branch.
REQ-011 SHALL provide port i_fb_outcome, input, BranchOutcome: actual outcome.
REQ-012 SHALL provide port i_fb_prediction, input, BranchOutcome: prediction carried with the branch.
REQ-013 SHALL provide port o_stat_branches, output, 32 bits: resolved-branch count; exists only with the stats macro.
REQ-014 SHALL provide port o_stat_mispredicts, output, 32 bits: mispredict count; exists only with the stats macro.

Function
REQ-015 SHALL hold 2^INDEX_BITS 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-016 SHALL use index = pc[INDEX_BITS+1:2], ignoring byte-offset bits, for both lookup and update.
REQ-017 SHALL compute o_prediction combinationally, with zero-cycle latency: TAKEN iff the effective counter bit[1]=1.
REQ-018 SHALL drive o_prediction NOT_TAKEN when i_req_valid=0.
REQ-019 SHALL register feedback in one pending-update stage (valid, index, new counter value) on the cycle i_fb_valid=1.
REQ-020 SHALL write the table on the following cycle.
REQ-021 SHALL compute the new counter value as: TAKEN -> increment, saturate at 11; NOT_TAKEN -> decrement, saturate at 00.
REQ-022 SHALL, when the pending update is valid and its index equals the lookup index, return a prediction that reflects the pending new value (bypass).
REQ-023 SHALL, when back-to-back feedback hits the same index, derive the second update from the pending value, not the stale table value; no update may be lost.
REQ-024 SHALL apply same-cycle lookup and feedback to the same index with the lookup seeing the pre-feedback value plus any older pending value.
REQ-025 SHALL let indices alias across PCs, with no tag check.
REQ-026 SHALL ignore i_fb_prediction except for statistics.

Reset
REQ-027 SHALL, on rst assertion and regardless of clk, set all counters to 01 (weak-NT) and clear the pending-update valid; an in-flight update is discarded.
REQ-028 SHALL hold o_prediction at NOT_TAKEN during reset.
REQ-029 SHALL clear both stat counters to 0 on reset.
REQ-030 SHALL make the first lookup after rst deassertion return NOT_TAKEN for every index.

Configuration
REQ-031 SHALL, with macro BRANCH_PREDICTOR_STATS_EN defined, increment o_stat_branches on each i_fb_valid cycle.
REQ-032 SHALL, with BRANCH_PREDICTOR_STATS_EN defined, increment o_stat_mispredicts when i_fb_prediction != i_fb_outcome; both counters saturate at 32'hFFFF_FFFF.
REQ-033 SHALL, without BRANCH_PREDICTOR_STATS_EN, omit both stat ports and their logic; prediction behaviour is identical in both builds.

Verification
REQ-034 SHALL cover reset then lookup of pc=0x0040_0010 -> NOT_TAKEN.
REQ-035 SHALL cover two TAKEN feedbacks for pc=0x0040_0010 on consecutive cycles -> counter 11; lookup two cycles later -> TAKEN.
REQ-036 SHALL cover bypass: feedback TAKEN for pc=0x0040_0020 (counter 01) at cycle N, lookup of same pc at N+1 -> TAKEN (10, still pending).
REQ-037 SHALL cover saturation: five NOT_TAKEN feedbacks on an index starting at 01 -> counter 00, no wrap to 11; lookup -> NOT_TAKEN.
REQ-038 SHALL cover aliasing: with INDEX_BITS=7, drive TAKEN twice to 0x0000_0004, then look up 0x0000_0204 -> TAKEN.
REQ-039 SHALL cover stats with BRANCH_PREDICTOR_STATS_EN: 10 feedbacks, 3 with prediction!=outcome -> o_stat_branches=10, o_stat_mispredicts=3; assert rst mid-update -> both 0, pending write dropped.
